// File: rtl/pal_macrocell_core.sv
// pal_macrocell_core
// ------------------
// Programmable PAL fabric: a shared AND plane of P product terms, an OR plane
// per output, and one macrocell per output that selects a combinational or
// registered result with programmable polarity. Macrocell register outputs
// (Q) feed back into the AND plane as literals. Only Q is fed back, never the
// combinational sum, so a programmed configuration cannot form a
// combinational loop.
//
// Configuration is shifted serially into a shadow chain and then committed
// in one step to the active configuration. The running fabric is driven only
// by the active copy, so it keeps operating while a new load is in progress.
//
// Active configuration layout (K = 2*(N+M) literals per term):
//   AND plane : bit p*K + k
//               k = 2i / 2i+1        -> INPUT_VARS[i] true / complement
//               k = 2(N+j) / +1      -> Q[j] true / complement
//   OR plane  : bit P*K + m*P + p
//   Macrocell : bit P*K + P*M + 2m   -> REG (1 = registered output)
//               bit P*K + P*M + 2m+1 -> INV (invert the sum)
//
// Ports:
//   CLK, RES_N   clock, asynchronous active-low reset
//   CFG_IN       serial configuration data
//   CFG_SHIFT    shift CFG_IN into the shadow chain this cycle
//   CFG_APPLY    commit shadow to active (needs exactly L bits, no error)
//   CFG_CLR      clear bit counter and CFG_ERR; wins over shift and apply
//   CFG_OUT      shadow[0], for readback or daisy-chaining
//   CFG_READY    bit counter equals L
//   CFG_ERR      sticky protocol error (overflow, bad apply, shift+apply)
//   CFG_ACTIVE   a configuration has been committed since reset
//   INPUT_VARS   N logic inputs
//   OUTPUT_VALS  M logic outputs
module pal_macrocell_core #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int P = 16
) (
    input  logic         CLK,
    input  logic         RES_N,
    input  logic         CFG_IN,
    input  logic         CFG_SHIFT,
    input  logic         CFG_APPLY,
    input  logic         CFG_CLR,
    output logic         CFG_OUT,
    output logic         CFG_READY,
    output logic         CFG_ERR,
    output logic         CFG_ACTIVE,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS
);

    localparam int K       = 2 * (N + M);
    localparam int L       = P * K + P * M + 2 * M;
    localparam int CW      = $clog2(L + 1);
    localparam int OR_BASE = P * K;
    localparam int MC_BASE = P * K + P * M;
    localparam logic [CW-1:0] L_CNT = CW'(L);

    logic [L-1:0]  shadow_q, shadow_d;
    logic [L-1:0]  active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          act_q, act_d;
    logic [M-1:0]  q_q, q_d;

    logic [K-1:0]  lits;
    logic [P-1:0]  term;
    logic [M-1:0]  sum;
    logic [M-1:0]  reg_sel;

    // ------------------------------------------------------------------
    // Fabric evaluation from the active configuration
    // ------------------------------------------------------------------
    always_comb begin
        lits = '0;
        for (int i = 0; i < N; i++) begin
            lits[2*i]   = INPUT_VARS[i];
            lits[2*i+1] = ~INPUT_VARS[i];
        end
        for (int j = 0; j < M; j++) begin
            lits[2*(N+j)]   = q_q[j];
            lits[2*(N+j)+1] = ~q_q[j];
        end
    end

    // A term with no literal selected would otherwise AND to 1; it is
    // forced to 0 so unprogrammed terms never contribute to a sum.
    always_comb begin
        term = '0;
        for (int p = 0; p < P; p++) begin
            term[p] = (|active_q[p*K +: K]) & (&(lits | ~active_q[p*K +: K]));
        end
    end

    always_comb begin
        sum     = '0;
        reg_sel = '0;
        for (int m = 0; m < M; m++) begin
            sum[m]     = (|(term & active_q[OR_BASE + m*P +: P]))
                         ^ active_q[MC_BASE + 2*m + 1];
            reg_sel[m] = active_q[MC_BASE + 2*m];
        end
    end

    assign OUTPUT_VALS = (reg_sel & q_q) | (~reg_sel & sum);

    // ------------------------------------------------------------------
    // Configuration loader and macrocell registers
    // ------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        act_d    = act_q;
        q_d      = sum;

        if (CFG_CLR) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (CFG_SHIFT && CFG_APPLY) begin
            err_d = 1'b1;
        end else if (CFG_SHIFT) begin
            // Shifting continues past L so the chain can still be used for
            // readback; the overflow is only flagged.
            shadow_d = {CFG_IN, shadow_q[L-1:1]};
            if (cnt_q == L_CNT) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (CFG_APPLY) begin
            if ((cnt_q == L_CNT) && !err_q) begin
                active_d = shadow_q;
                cnt_d    = '0;
                act_d    = 1'b1;
                // Macrocells start the new configuration from a known state.
                q_d      = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            act_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            act_q    <= act_d;
            q_q      <= q_d;
        end
    end

    assign CFG_OUT    = shadow_q[0];
    assign CFG_READY  = (cnt_q == L_CNT);
    assign CFG_ERR    = err_q;
    assign CFG_ACTIVE = act_q;

endmodule

// File: tb/tb_pal_macrocell_core.sv
// tb_pal_macrocell_core
// ---------------------
// Directed bench for pal_macrocell_core with default parameters
// (N=8, M=4, P=16, L=456). Inputs are driven 1 time unit after the rising
// edge and outputs are sampled at least 1 time unit after that, well away
// from the active edge.
module tb_pal_macrocell_core;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int P  = 16;
    localparam int K  = 2 * (N + M);
    localparam int L  = P * K + P * M + 2 * M;
    localparam int OR_BASE = P * K;
    localparam int MC_BASE = P * K + P * M;

    logic         clk;
    logic         rst_n;
    logic         cfg_in;
    logic         cfg_shift;
    logic         cfg_apply;
    logic         cfg_clr;
    logic         cfg_out;
    logic         cfg_ready;
    logic         cfg_err;
    logic         cfg_active;
    logic [N-1:0] in_vars;
    logic [M-1:0] out_vals;

    int checks = 0;
    int errors = 0;
    int tog_ticks = 0;          // edges since the toggle config was applied
    logic [0:0] exp_q[$];       // expected readback sequence on CFG_OUT

    logic [L-1:0] cfg_inv0;
    logic [L-1:0] cfg_and;
    logic [L-1:0] cfg_tog;
    logic [L-1:0] cfg_ones;

    pal_macrocell_core #(.N(N), .M(M), .P(P)) dut (
        .CLK         (clk),
        .RES_N       (rst_n),
        .CFG_IN      (cfg_in),
        .CFG_SHIFT   (cfg_shift),
        .CFG_APPLY   (cfg_apply),
        .CFG_CLR     (cfg_clr),
        .CFG_OUT     (cfg_out),
        .CFG_READY   (cfg_ready),
        .CFG_ERR     (cfg_err),
        .CFG_ACTIVE  (cfg_active),
        .INPUT_VARS  (in_vars),
        .OUTPUT_VALS (out_vals)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        tog_ticks++;
    endtask

    task automatic shift_bit(input logic b);
        cfg_in    = b;
        cfg_shift = 1'b1;
        tick();
        cfg_shift = 1'b0;
    endtask

    task automatic shift_n(input int n, input logic b);
        for (int i = 0; i < n; i++) shift_bit(b);
    endtask

    task automatic load_cfg(input logic [L-1:0] c, input int nbits);
        for (int i = 0; i < nbits; i++) shift_bit(c[i]);
    endtask

    task automatic do_apply();
        cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
    endtask

    task automatic do_clr();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        cfg_in    = 1'b0;
        cfg_shift = 1'b0;
        cfg_apply = 1'b0;
        cfg_clr   = 1'b0;
        in_vars   = '0;

        cfg_inv0 = '0;
        cfg_inv0[MC_BASE + 1] = 1'b1;             // INV0

        cfg_and = '0;
        cfg_and[0] = 1'b1;                        // term0: in0 true
        cfg_and[2] = 1'b1;                        // term0: in1 true
        cfg_and[OR_BASE + 1*P + 0] = 1'b1;        // out1 <- term0

        cfg_tog = '0;
        cfg_tog[2*N + 1] = 1'b1;                  // term0: Q0 complement
        cfg_tog[OR_BASE + 0] = 1'b1;              // out0 <- term0
        cfg_tog[MC_BASE + 0] = 1'b1;              // REG0

        cfg_ones = '1;

        // Reset state, checked before any clock edge
        #1;
        check("rst_out",    32'(out_vals),   32'h0);
        check("rst_cfgout", 32'(cfg_out),    32'h0);
        check("rst_ready",  32'(cfg_ready),  32'h0);
        check("rst_err",    32'(cfg_err),    32'h0);
        check("rst_active", 32'(cfg_active), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: constant output through INV0
        load_cfg(cfg_inv0, L);
        check("t1_ready_pre", 32'(cfg_ready), 32'h1);
        check("t1_err_pre",   32'(cfg_err),   32'h0);
        do_apply();
        check("t1_active", 32'(cfg_active), 32'h1);
        check("t1_ready",  32'(cfg_ready),  32'h0);
        in_vars = 8'h00; #1; check("t1_out_00", 32'(out_vals), 32'h1);
        in_vars = 8'hA5; #1; check("t1_out_a5", 32'(out_vals), 32'h1);
        in_vars = 8'hFF; #1; check("t1_out_ff", 32'(out_vals), 32'h1);

        // 2: combinational AND term on out1
        load_cfg(cfg_and, L);
        do_apply();
        in_vars = 8'h03; #1; check("t2_out_03", 32'(out_vals), 32'h2);
        in_vars = 8'h01; #1; check("t2_out_01", 32'(out_vals), 32'h0);
        in_vars = 8'h02; #1; check("t2_out_02", 32'(out_vals), 32'h0);
        in_vars = 8'hFF; #1; check("t2_out_ff", 32'(out_vals), 32'h2);
        in_vars = 8'h07; #1; check("t2_out_07", 32'(out_vals), 32'h2);

        // 3: registered toggle on out0 through Q0 feedback
        load_cfg(cfg_tog, L);
        do_apply();
        tog_ticks = 0;
        check("t3_out_apply", 32'(out_vals), 32'h0);
        tick(); check("t3_tog1", 32'(out_vals), 32'h1);
        tick(); check("t3_tog2", 32'(out_vals), 32'h0);
        tick(); check("t3_tog3", 32'(out_vals), 32'h1);

        // 4: short load, clear, overflow; active toggle keeps running
        load_cfg(cfg_ones, L - 1);
        check("t4_ready_455", 32'(cfg_ready), 32'h0);
        do_apply();
        check("t4_err_short", 32'(cfg_err),    32'h1);
        check("t4_active",    32'(cfg_active), 32'h1);
        check("t4_out_kept",  32'(out_vals),   32'(tog_ticks % 2));
        tick();
        check("t4_out_kept2", 32'(out_vals),   32'(tog_ticks % 2));
        do_clr();
        check("t4_err_clr",   32'(cfg_err),   32'h0);
        check("t4_ready_clr", 32'(cfg_ready), 32'h0);
        load_cfg(cfg_ones, L);
        check("t4_err_456",   32'(cfg_err),   32'h0);
        shift_bit(1'b1);
        check("t4_err_457",   32'(cfg_err),   32'h1);
        check("t4_ready_457", 32'(cfg_ready), 32'h1);
        check("t4_out_run",   32'(out_vals),  32'(tog_ticks % 2));
        do_clr();

        // 5: readback of an alternating pattern, first bit out first
        for (int i = 0; i < L; i++) begin
            exp_q.push_back(((i % 2) == 0) ? 1'b1 : 1'b0);
            shift_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < L; i++) begin
            check($sformatf("t5_rb%0d", i), 32'(cfg_out), 32'(exp_q.pop_front()));
            shift_bit(1'b0);
        end
        check("t5_err_ovf", 32'(cfg_err), 32'h1);
        do_clr();
        load_cfg(cfg_inv0, L);
        cfg_shift = 1'b1;
        cfg_apply = 1'b1;
        tick();
        cfg_shift = 1'b0;
        cfg_apply = 1'b0;
        check("t5_err_both",   32'(cfg_err),   32'h1);
        check("t5_ready_both", 32'(cfg_ready), 32'h1);
        check("t5_nocommit1",  32'(out_vals),  32'(tog_ticks % 2));
        tick();
        check("t5_nocommit2",  32'(out_vals),  32'(tog_ticks % 2));

        // 6: asynchronous reset mid-load with a registered output at 1
        do_clr();
        shift_n(200, 1'b1);
        if ((tog_ticks % 2) == 0) tick();
        check("t6_out_pre", 32'(out_vals), 32'h1);
        rst_n = 1'b0;
        #2;
        check("t6_out_rst",    32'(out_vals),   32'h0);
        check("t6_active_rst", 32'(cfg_active), 32'h0);
        check("t6_ready_rst",  32'(cfg_ready),  32'h0);
        check("t6_err_rst",    32'(cfg_err),    32'h0);
        check("t6_cfgout_rst", 32'(cfg_out),    32'h0);
        tick();
        rst_n = 1'b1;
        // The discarded 200 bits must not count toward the next load.
        shift_n(256, 1'b0);
        check("t6_ready_partial", 32'(cfg_ready), 32'h0);
        shift_n(200, 1'b0);
        check("t6_ready_full", 32'(cfg_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pal_macrocell_core.md
Name: pal_macrocell_core

Overview:
- Parametrised next-generation PAL fabric: programmable AND plane, OR plane and per-output macrocell.
- Each output is selectable as combinational or registered, with programmable polarity.
- Macrocell register outputs feed back into the AND plane, so small state machines can be programmed into the fabric.
- Configuration is loaded serially into a shadow chain (with bit counting, error flagging and readback), then committed atomically to the active fabric.

Parameters:
- N, 8, number of primary inputs
- M, 4, number of outputs/macrocells
- P, 16, number of product terms (shared by all outputs)
- Derived K = 2*(N+M) literals; L = P*K + P*M + 2*M config bits (default 456); CW = clog2(L+1)

Ports:
- CLK  in  1  clock
- RES_N  in  1  reset; one clock, asynchronous active-low reset
- CFG_IN  in  1  serial config data
- CFG_SHIFT  in  1  shift CFG_IN into shadow chain this cycle
- CFG_APPLY  in  1  commit shadow to active config
- CFG_CLR  in  1  clear bit counter and CFG_ERR (shadow contents untouched)
- CFG_OUT  out  1  shadow[0], readback/daisy-chain
- CFG_READY  out  1  bit counter == L
- CFG_ERR  out  1  sticky protocol error
- CFG_ACTIVE  out  1  a valid config has been applied since reset
- INPUT_VARS  in  N  logic inputs
- OUTPUT_VALS  out  M  logic outputs

Behaviour:
- Reset (async, RES_N=0):
  - shadow=0, active=0, counter=0, CFG_ERR=0, CFG_ACTIVE=0, macrocell regs=0.
  - Result: OUTPUT_VALS=0, CFG_OUT=0, CFG_READY=0.
  - A reset mid-load discards the partial load.
- Shift, when CFG_SHIFT=1 and CFG_APPLY=0:
  - shadow <= {CFG_IN, shadow[L-1:1]}.
  - If counter<L, counter++.
  - If counter==L, the shift still occurs, counter stays L, CFG_ERR<=1 (overflow).
  - The first bit shifted ends at shadow[0] after L shifts.
- Apply, when CFG_APPLY=1 and CFG_SHIFT=0:
  - If counter==L and CFG_ERR=0: active<=shadow, counter<=0, CFG_ACTIVE<=1, all macrocell regs<=0 in the same edge.
  - Otherwise: no commit, CFG_ERR<=1.
- CFG_SHIFT and CFG_APPLY high in the same cycle: neither acts; CFG_ERR<=1.
- CFG_CLR has priority over shift and apply: counter<=0, CFG_ERR<=0, nothing else changes.
- Active config layout (index into active):
  - AND plane, term p, literal k: bit p*K+k.
    - Literal 2i / 2i+1 = INPUT_VARS[i] true/complement, i<N.
    - Literal 2(N+j) / 2(N+j)+1 = feedback Q[j] true/complement.
  - OR plane, output m, term p: bit P*K + m*P + p.
  - Macrocell m: bit P*K+P*M+2m = REG (1 = registered), bit +1 = INV.
- Logic:
  - term[p] = AND of the selected literals; a term with no literal selected = 0.
  - sum[m] = OR of the selected terms, XOR INV[m].
  - Q[m] <= sum[m] on every CLK edge (no enable).
  - OUTPUT_VALS[m] = REG ? Q[m] : sum[m].
- Feedback always uses Q, never sum, so no combinational loops can be programmed.
- Latency:
  - Combinational outputs follow INPUT_VARS within the same cycle.
  - Registered outputs update one edge later.
  - A new config takes effect on the edge after CFG_APPLY is sampled.
- Loading does not disturb the running fabric; active logic keeps operating during shifts.

Test Plan:
- Reset, then 456 shifts of a pattern with INV0=1 (all other bits 0), then APPLY -> CFG_READY=1 before apply; after apply CFG_ACTIVE=1, counter 0, OUTPUT_VALS=4'b0001 for any input.
- Program term0 = in0 AND in1, OR'd to out1, combinational -> INPUT_VARS=8'h03 gives out1=1 same cycle; 8'h01 gives out1=0.
- Program out0 registered toggle (term0 = Q0 complement, OR to out0, REG0=1) -> out0 is 0 after apply and toggles 1,0,1 on successive edges.
- APPLY after 455 shifts -> CFG_ERR=1, active config unchanged. CFG_CLR -> CFG_ERR=0, counter=0. 457 shifts -> CFG_ERR=1.
- Shift an alternating 1010… pattern of L bits, then shift L more zeros -> CFG_OUT reproduces the original sequence in order; CFG_SHIFT and CFG_APPLY high together -> CFG_ERR=1, no commit.
- Assert RES_N=0 mid-load (after 200 shifts) and while registered outputs are 1 -> OUTPUT_VALS=0, CFG_ACTIVE=0, CFG_READY=0 immediately, without waiting for a clock.
